// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation codes,
// controller states and the Start-to-Done latency used by the stall logic.
package mult_div_unit_pkg;

  typedef enum logic [1:0] {
    MD_MULTU = 2'b00,
    MD_MULT  = 2'b01,
    MD_DIVU  = 2'b10,
    MD_DIV   = 2'b11
  } md_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } md_state_e;

  localparam int unsigned MD_DEFAULT_WIDTH = 32;
  localparam int unsigned MD_LATENCY_EXTRA = 2;
  localparam int unsigned MD_LATENCY       = MD_DEFAULT_WIDTH + MD_LATENCY_EXTRA;

  // Edges from the accepting Start edge to the edge that writes HI/LO.
  function automatic int unsigned md_latency(input int unsigned width);
    return width + MD_LATENCY_EXTRA;
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative signed/unsigned multiply and divide with HI/LO result registers.
// Fixed latency: PREP, WIDTH CALC steps, FIX, then a one-cycle DONE.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [1:0]       MDOperation,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             DivByZero
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  md_state_e          state;
  md_op_e             op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   opb;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;
  logic               neg_p;
  logic               neg_r;

  logic               is_div;
  logic               is_signed;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     add_a;
  logic [WIDTH:0]     add_b;
  logic [WIDTH:0]     add_cin;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    is_div    = (op_q == MD_DIVU) || (op_q == MD_DIV);
    is_signed = (op_q == MD_MULT) || (op_q == MD_DIV);
    a_mag     = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
    b_mag     = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;
  end

  // One WIDTH+1 adder serves both the shift-add and the restoring subtract.
  always_comb begin
    if (is_div) begin
      add_a   = acc[2*WIDTH-2:WIDTH-1];
      add_b   = ~{1'b0, opb};
      add_cin = {{WIDTH{1'b0}}, 1'b1};
    end else begin
      add_a   = {1'b0, acc[2*WIDTH-1:WIDTH]};
      add_b   = {1'b0, opb};
      add_cin = '0;
    end
    sum = add_a + add_b + add_cin;
  end

  always_comb begin
    acc_next = acc;
    if (is_div) begin
      if (!sum[WIDTH]) begin
        acc_next = {sum[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {acc[2*WIDTH-2:0], 1'b0};
      end
    end else begin
      if (acc[0]) begin
        acc_next = {sum, acc[WIDTH-1:1]};
      end else begin
        acc_next = {1'b0, acc[2*WIDTH-1:1]};
      end
    end
  end

  always_comb begin
    prod_fix = neg_p ? -acc : acc;
    quo_fix  = neg_p ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      HI        <= '0;
      LO        <= '0;
      DivByZero <= 1'b0;
      cnt       <= '0;
      op_q      <= MD_MULTU;
      a_q       <= '0;
      b_q       <= '0;
      opb       <= '0;
      acc       <= '0;
      neg_p     <= 1'b0;
      neg_r     <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          Done <= 1'b0;
          if (Start) begin
            op_q      <= md_op_e'(MDOperation);
            a_q       <= A;
            b_q       <= B;
            DivByZero <= 1'b0;
            Busy      <= 1'b1;
            state     <= S_PREP;
          end else begin
            state <= S_IDLE;
          end
        end
        S_PREP: begin
          acc   <= {{WIDTH{1'b0}}, a_mag};
          opb   <= b_mag;
          neg_p <= is_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          neg_r <= is_signed && a_q[WIDTH-1];
          cnt   <= '0;
          state <= S_CALC;
        end
        S_CALC: begin
          acc <= acc_next;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            cnt   <= '0;
            state <= S_FIX;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_FIX: begin
          if (is_div) begin
            // Divide by zero reports the raw dividend regardless of signedness.
            if (b_q == '0) begin
              HI        <= a_q;
              LO        <= '1;
              DivByZero <= 1'b1;
            end else begin
              HI        <= rem_fix;
              LO        <= quo_fix;
              DivByZero <= 1'b0;
            end
          end else begin
            HI        <= prod_fix[2*WIDTH-1:WIDTH];
            LO        <= prod_fix[WIDTH-1:0];
            DivByZero <= 1'b0;
          end
          Busy  <= 1'b0;
          Done  <= 1'b1;
          state <= S_DONE;
        end
        default: begin
          Busy  <= 1'b0;
          Done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: results, fixed latency, Busy/Done timing,
// divide-by-zero flag behaviour and mid-operation reset.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        Start;
  logic [1:0]  MDOperation;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic        Done;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        DivByZero;

  int checks   = 0;
  int failures = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .Start      (Start),
    .MDOperation(MDOperation),
    .A          (A),
    .B          (B),
    .Busy       (Busy),
    .Done       (Done),
    .HI         (HI),
    .LO         (LO),
    .DivByZero  (DivByZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issues one operation, scrambles the input buses after acceptance, and
  // waits (bounded) for Done while measuring latency and Busy duration.
  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp_res, input logic exp_dbz);
    int n;
    int busy_n;
    @(negedge clk);
    Start = 1'b1; MDOperation = op; A = a; B = b;
    @(posedge clk); #1;
    Start = 1'b0; MDOperation = ~op; A = ~a; B = ~b;
    check({tag, "_busy_start"}, 64'(Busy), 64'd1);
    check({tag, "_done_start"}, 64'(Done), 64'd0);
    check({tag, "_dbz_clear"}, 64'(DivByZero), 64'd0);
    n = 0;
    busy_n = 0;
    while (!Done && n < 100) begin
      if (Busy) busy_n++;
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'd34);
    check({tag, "_busy_cycles"}, 64'(busy_n), 64'd34);
    check({tag, "_busy_at_done"}, 64'(Busy), 64'd0);
    check({tag, "_hilo"}, {HI, LO}, exp_res);
    check({tag, "_dbz"}, 64'(DivByZero), 64'(exp_dbz));
  endtask

  task automatic idle_gap(input string tag);
    @(posedge clk); #1;
    check({tag, "_done_drop"}, 64'(Done), 64'd0);
    check({tag, "_idle_busy"}, 64'(Busy), 64'd0);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    reset = 1'b1; Start = 1'b0; MDOperation = 2'b00; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_done", 64'(Done), 64'd0);
    check("rst_hilo", {HI, LO}, 64'd0);
    check("rst_dbz", 64'(DivByZero), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    do_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0);
    idle_gap("g1");
    do_op("mult_neg", 2'b01, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
    // Back-to-back: the next Start is raised during the DONE cycle.
    do_op("multu_shift", 2'b00, 32'h1234_5678, 32'h10, 64'h0000_0001_2345_6780, 1'b0);
    do_op("mult_minmin", 2'b01, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0);
    idle_gap("g2");
    do_op("div_neg", 2'b11, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    do_op("div_negb", 2'b11, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 1'b0);
    do_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0);
    idle_gap("g3");
    do_op("divu_zero", 2'b10, 32'd100, 32'd0, 64'h0000_0064_FFFF_FFFF, 1'b1);
    idle_gap("g4");
    check("dbz_hold", 64'(DivByZero), 64'd1);
    do_op("divu_after", 2'b10, 32'd1000, 32'd7, 64'h0000_0006_0000_008E, 1'b0);
    do_op("div_zero_s", 2'b11, 32'hFFFF_FFFB, 32'd0, 64'hFFFF_FFFB_FFFF_FFFF, 1'b1);
    idle_gap("g5");

    // Interrupted operation: ignored Start while busy, then reset mid-CALC.
    @(negedge clk);
    Start = 1'b1; MDOperation = 2'b00; A = 32'd5; B = 32'd6;
    @(posedge clk); #1;
    Start = 1'b0;
    check("intr_busy", 64'(Busy), 64'd1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    Start = 1'b1; MDOperation = 2'b10; A = 32'd9; B = 32'd9;
    @(posedge clk); #1;
    Start = 1'b0;
    check("intr_ignored_busy", 64'(Busy), 64'd1);
    check("intr_ignored_done", 64'(Done), 64'd0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1; Start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; Start = 1'b0;
    check("intr_rst_busy", 64'(Busy), 64'd0);
    check("intr_rst_done", 64'(Done), 64'd0);
    check("intr_rst_hilo", {HI, LO}, 64'd0);
    check("intr_rst_dbz", 64'(DivByZero), 64'd0);
    do_op("divu_17_5", 2'b10, 32'd17, 32'd5, 64'h0000_0002_0000_0003, 1'b0);
    idle_gap("g6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit in the execute stage, alongside the ALU. It takes the same A/B operand buses, runs signed or unsigned 32×32 multiplication or division over a fixed number of cycles, and holds the 64-bit result in HI/LO registers for later move-from-HI/LO reads. Its Busy output drives the pipeline stall logic while an operation is in flight.

## Interface
- WIDTH, 32, operand width; HI and LO are WIDTH bits each.
- clk  input  1  clock, all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- Start  input  1  request; sampled only in IDLE or DONE.
- MDOperation  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- A  input  WIDTH  multiplicand or dividend.
- B  input  WIDTH  multiplier or divisor.
- Busy  output  1  high in PREP, CALC and FIX.
- Done  output  1  one-cycle pulse in DONE.
- HI  output  WIDTH  product upper half, or division remainder.
- LO  output  WIDTH  product lower half, or division quotient.
- DivByZero  output  1  set by a DIV/DIVU with B==0; cleared by the next accepted Start.

## Operation
- States and transitions:
  - IDLE → PREP on Start.
  - PREP → CALC.
  - CALC loops WIDTH edges, then → FIX.
  - FIX → DONE.
  - DONE → PREP if Start, else → IDLE.
- Start accepted: latch MDOperation, A and B internally. Later changes on the input buses have no effect. DivByZero is cleared.
- PREP: for signed operations (MULT, DIV), take the magnitudes of the operands and record the result signs:
  - product sign = sign(A) XOR sign(B);
  - quotient sign = sign(A) XOR sign(B);
  - remainder sign = sign(A).
- CALC, multiply: radix-2 shift-add, one multiplier bit per edge, with a 2·WIDTH-bit accumulator.
- CALC, divide: radix-2 restoring, one quotient bit per edge.
- FIX: negate the results where the recorded signs require it, then write HI/LO.
- Multiply result: {HI,LO} is the full 2·WIDTH-bit two's-complement (MULT) or unsigned (MULTU) product. No overflow is possible.
- Divide result: the quotient truncates toward zero; the remainder takes the dividend's sign, so A = LO·B + HI.
- Overflow case DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. The result wraps and no flag is raised.
- Divide by zero (B==0, DIV or DIVU): same latency as any other operation. Result is HI=A, LO=all ones, DivByZero=1.
- HI, LO and DivByZero hold their values until the next FIX or reset.
- Start while Busy: ignored, with no queuing.
- Start high in DONE: accepted, giving back-to-back operation with no IDLE cycle.
- Reset at any time, including mid-CALC, takes effect at the next edge:
  - state=IDLE;
  - Busy=0, Done=0;
  - HI=0, LO=0, DivByZero=0;
  - the iteration counter is cleared.
- Reset dominates Start in the same cycle.

## Timing
- Start is sampled high at edge N.
- Busy=1 from edge N through edge N+WIDTH+2.
- HI/LO/DivByZero are written at edge N+WIDTH+2 (edge N+34 for WIDTH=32).
- Done=1 for exactly the cycle between edges N+WIDTH+2 and N+WIDTH+3.
- Fixed latency for every operation and operand value; no early termination.
- Back-to-back: a Start held high in DONE is accepted at edge N+WIDTH+3. Busy is high again after that edge and Done drops.
- The outputs are registers only; there is no combinational path from the inputs to Busy/Done/HI/LO.
- The iteration counter is $clog2(WIDTH)+1 bits and counts 0..WIDTH-1 in CALC.

## Structure
- Shared package holds:
  - the MDOperation encodings (MULTU/MULT/DIVU/DIV);
  - the state encoding (IDLE, PREP, CALC, FIX, DONE);
  - the Start-to-Done latency constant WIDTH+2, so the stall/hazard unit uses the same value.
- Single module. The shift-add and restoring-subtract steps share one WIDTH+1-bit adder and one 2·WIDTH-bit shift register, so no sub-module is warranted.

## Test plan
- MULTU A=0xFFFFFFFF B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. Done exactly at edge N+34; Busy high for 34 cycles.
- MULT A=0xFFFFFFFD (−3) B=7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB (−21).
- DIV A=0xFFFFFFF9 (−7) B=2 → LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1).
- DIV A=0x80000000 B=0xFFFFFFFF → LO=0x80000000, HI=0, DivByZero=0.
- DIVU A=100 B=0 → HI=0x00000064, LO=0xFFFFFFFF, DivByZero=1. The next accepted Start clears DivByZero at its sampling edge.
- Interrupted operation, in sequence:
  1. Start MULTU 5×6.
  2. Pulse Start at N+5 → ignored.
  3. Assert reset at N+10 → Busy=0, HI=LO=0, no Done pulse.
  4. Start DIVU 17/5 in the next cycle → HI=2, LO=3, 34 cycles later.
